// File: rtl/exchange_msg_tx_pkg.sv
// Shared types and constants for the exchange message transmitter.
package cache_def;

    localparam int unsigned EXCH_ID_W  = 5;
    localparam int unsigned EXCH_AMT_W = 16;

    typedef struct packed {
        logic [EXCH_ID_W-1:0]  client_id;
        logic [EXCH_AMT_W-1:0] amount;
    } exch_msg_t;

    typedef enum logic [1:0] {IDLE, PULSE, GAP} tx_state_t;

    function automatic logic [EXCH_AMT_W-1:0] sat_add(input logic [EXCH_AMT_W-1:0] a,
                                                      input logic [EXCH_AMT_W-1:0] b);
        logic [EXCH_AMT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[EXCH_AMT_W] ? '1 : sum[EXCH_AMT_W-1:0];
    endfunction

endpackage

// File: rtl/exchange_msg_tx_fifo.sv
// Message FIFO for exchange_msg_tx. With EXCH_TX_COALESCE_EN defined, a push matching the
// newest entry's client_id adds into that entry instead of allocating a slot.
module exch_tx_fifo
    import cache_def::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   HRESETn,
    input  logic                   push,
    input  exch_msg_t              push_msg,
    input  logic                   pop,
    output exch_msg_t              head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    exch_msg_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          alloc;

`ifdef EXCH_TX_COALESCE_EN
    logic [AW-1:0] last_ptr;
    logic          merge;

    assign last_ptr = wr_ptr_q - AW'(1);
    // The newest entry is only the one leaving when it is also the sole entry.
    assign merge = push && (count_q != '0) &&
                   (mem[last_ptr].client_id == push_msg.client_id) &&
                   !(pop && (count_q == CW'(1)));
    assign alloc = push && !merge;

    always_ff @(posedge clk) begin
        if (alloc) begin
            mem[wr_ptr_q] <= push_msg;
        end else if (merge) begin
            mem[last_ptr].amount <= sat_add(mem[last_ptr].amount, push_msg.amount);
        end
    end
`else
    assign alloc = push;

    always_ff @(posedge clk) begin
        if (alloc) begin
            mem[wr_ptr_q] <= push_msg;
        end
    end
`endif

    assign head  = mem[rd_ptr_q];
    assign count = count_q;

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (alloc) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(alloc) - CW'(pop);
        end
    end

endmodule

// File: rtl/exchange_msg_tx.sv
// Queues exchange cancel/fill messages and emits them as spaced one-cycle strobes, deferring
// to the CPU order path. Optional coalescing of same-client messages: EXCH_TX_COALESCE_EN.
module exchange_msg_tx
    import cache_def::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   HRESETn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXCH_ID_W-1:0]   in_client_id,
    input  logic [EXCH_AMT_W-1:0]  in_amount,
    input  logic                   cpu_busy,
    output logic                   exchange_go,
    output logic [EXCH_ID_W-1:0]   exchange_client_id,
    output logic [EXCH_AMT_W-1:0]  exchange_amount,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            sent_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_t     state_q;
    logic [GW-1:0] gap_cnt_q;
    exch_msg_t     in_msg;
    exch_msg_t     head;
    logic          push;
    logic          pop;
    logic          empty;

    assign in_msg   = '{client_id: in_client_id, amount: in_amount};
    assign empty    = (fifo_count == '0);
    assign in_ready = HRESETn && (fifo_count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    // Head is captured and popped on the same edge that launches the strobe.
    assign pop      = (state_q == IDLE) && !empty && !cpu_busy;

    exch_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .HRESETn  (HRESETn),
        .push     (push),
        .push_msg (in_msg),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q            <= IDLE;
            gap_cnt_q          <= '0;
            exchange_go        <= 1'b0;
            exchange_client_id <= '0;
            exchange_amount    <= '0;
            sent_count         <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q            <= PULSE;
                        exchange_go        <= 1'b1;
                        exchange_client_id <= head.client_id;
                        exchange_amount    <= head.amount;
                        sent_count         <= sent_count + 16'd1;
                    end
                end
                PULSE: begin
                    state_q     <= GAP;
                    exchange_go <= 1'b0;
                    gap_cnt_q   <= '0;
                end
                GAP: begin
                    if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    exchange_go <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exchange_msg_tx.sv
// Self-checking bench for exchange_msg_tx: vector table plus scoreboard-checked corner sequences.
module tb_exchange_msg_tx;
    import cache_def::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned GAP   = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          HRESETn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_client_id = '0;
    logic [15:0]   in_amount = '0;
    logic          cpu_busy = 1'b0;
    logic          exchange_go;
    logic [4:0]    exchange_client_id;
    logic [15:0]   exchange_amount;
    logic [CW-1:0] fifo_count;
    logic [15:0]   sent_count;

    always #5 clk = ~clk;

    exchange_msg_tx #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk                (clk),
        .HRESETn            (HRESETn),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_client_id       (in_client_id),
        .in_amount          (in_amount),
        .cpu_busy           (cpu_busy),
        .exchange_go        (exchange_go),
        .exchange_client_id (exchange_client_id),
        .exchange_amount    (exchange_amount),
        .fifo_count         (fifo_count),
        .sent_count         (sent_count)
    );

    typedef struct {
        logic [4:0]  id;
        logic [15:0] amt;
    } msg_t;

    typedef struct {
        logic [4:0]  id;
        logic [15:0] amt;
        logic [4:0]  exp_id;
        logic [15:0] exp_amt;
    } vec_t;

    msg_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   low_run = 0;
    bit   prev_go = 1'b0;
    bit   pulse_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, where pulses are scoreboarded.
    task automatic tick();
        msg_t e;
        @(posedge clk);
        #1;
        if (exchange_go === 1'b1) begin
            pulses++;
            chk("go_one_cycle", 32'(prev_go), 32'd0);
            if (pulse_seen) chk("gap_low_cycles", 32'(low_run >= int'(GAP)), 32'd1);
            chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pulse_id", 32'(exchange_client_id), 32'(e.id));
                chk("pulse_amt", 32'(exchange_amount), 32'(e.amt));
            end
            low_run    = 0;
            pulse_seen = 1'b1;
        end else begin
            low_run++;
        end
        prev_go = (exchange_go === 1'b1);
    endtask

`ifdef EXCH_TX_COALESCE_EN
    function automatic logic [15:0] model_sat(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'(a) + int'(b);
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction
`endif

    task automatic push(input logic [4:0] id, input logic [15:0] amt,
                        input logic [4:0] exp_id, input logic [15:0] exp_amt);
        bit   acc;
        msg_t m;
        acc          = 1'b0;
        in_valid     = 1'b1;
        in_client_id = id;
        in_amount    = amt;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (in_ready === 1'b1) begin
                acc   = 1'b1;
                m.id  = exp_id;
                m.amt = exp_amt;
`ifdef EXCH_TX_COALESCE_EN
                // With the transmitter blocked nothing pops, so the newest entry is mergeable.
                if (cpu_busy && sb.size() != 0 && sb[sb.size()-1].id == exp_id) begin
                    m     = sb.pop_back();
                    m.amt = model_sat(m.amt, exp_amt);
                end
`endif
                sb.push_back(m);
            end
            tick();
        end
        in_valid = 1'b0;
        chk("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || exchange_go === 1'b1) && n < 1000) begin
            tick();
            n++;
        end
        repeat (GAP + 4) tick();
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_fifo_empty", 32'(fifo_count), 32'd0);
    endtask

    task automatic wait_pulse(input int target);
        int n;
        n = 0;
        while (pulses < target && n < 200) begin
            tick();
            n++;
        end
        chk("wait_pulse_seen", 32'(pulses >= target), 32'd1);
    endtask

    initial begin
        vec_t vt[8];
        msg_t m;
        int   base;

        vt[0] = '{5'd1,  16'd0,     5'd1,  16'd0};
        vt[1] = '{5'd2,  16'hFFFF,  5'd2,  16'hFFFF};
        vt[2] = '{5'd31, 16'h8000,  5'd31, 16'h8000};
        vt[3] = '{5'd0,  16'd1,     5'd0,  16'd1};
        vt[4] = '{5'd17, 16'h1234,  5'd17, 16'h1234};
        vt[5] = '{5'd2,  16'h00FF,  5'd2,  16'h00FF};
        vt[6] = '{5'd9,  16'd0,     5'd9,  16'd0};
        vt[7] = '{5'd30, 16'hA5A5,  5'd30, 16'hA5A5};

        // Reset state.
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_go", 32'(exchange_go), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_sent_count", 32'(sent_count), 32'd0);
        chk("rst_id", 32'(exchange_client_id), 32'd0);
        chk("rst_amt", 32'(exchange_amount), 32'd0);
        HRESETn = 1'b1;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Latency: accepted on one edge, strobe visible after the next one.
        m.id = 5'd3;
        m.amt = 16'd100;
        in_valid = 1'b1;
        in_client_id = 5'd3;
        in_amount = 16'd100;
        chk("lat_ready", 32'(in_ready), 32'd1);
        sb.push_back(m);
        tick();
        in_valid = 1'b0;
        chk("lat_edge1_go", 32'(exchange_go), 32'd0);
        chk("lat_edge1_count", 32'(fifo_count), 32'd1);
        tick();
        chk("lat_edge2_go", 32'(exchange_go), 32'd1);
        chk("lat_sent", 32'(sent_count), 32'd1);
        tick();
        chk("lat_pulse_end", 32'(exchange_go), 32'd0);
        chk("lat_hold_id", 32'(exchange_client_id), 32'd3);
        chk("lat_hold_amt", 32'(exchange_amount), 32'd100);

        // Vector table, back-to-back pushes with the transmitter free.
        foreach (vt[i]) push(vt[i].id, vt[i].amt, vt[i].exp_id, vt[i].exp_amt);
        drain();
        chk("table_sent", 32'(sent_count), 32'd9);

        // Blocked by cpu_busy, then busy rising mid-pulse.
        cpu_busy = 1'b1;
        push(5'd10, 16'd10, 5'd10, 16'd10);
        push(5'd11, 16'd11, 5'd11, 16'd11);
        push(5'd12, 16'd12, 5'd12, 16'd12);
        base = pulses;
        repeat (6) tick();
        chk("busy_no_pulse", 32'(pulses - base), 32'd0);
        chk("busy_count", 32'(fifo_count), 32'd3);
        cpu_busy = 1'b0;
        wait_pulse(base + 1);
        cpu_busy = 1'b1;
        repeat (8) tick();
        chk("busy_mid_pulses", 32'(pulses - base), 32'd1);
        chk("busy_mid_count", 32'(fifo_count), 32'd2);
        cpu_busy = 1'b0;
        drain();
        chk("busy_total_pulses", 32'(pulses - base), 32'd3);

        // Full FIFO: ninth message waits for a pop.
        cpu_busy = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            push(5'(20 + i), 16'(100 + i), 5'(20 + i), 16'(100 + i));
        end
        chk("full_count", 32'(fifo_count), 32'(DEPTH));
        chk("full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_client_id = 5'd28;
        in_amount = 16'd999;
        repeat (3) tick();
        chk("full_hold_count", 32'(fifo_count), 32'(DEPTH));
        base = pulses;
        cpu_busy = 1'b0;
        push(5'd28, 16'd999, 5'd28, 16'd999);
        chk("full_accept_after_pop", 32'(pulses - base), 32'd1);
        drain();

        // Same-client pair while blocked.
        cpu_busy = 1'b1;
        push(5'd5, 16'hFFF0, 5'd5, 16'hFFF0);
        push(5'd5, 16'h0020, 5'd5, 16'h0020);
        base = pulses;
`ifdef EXCH_TX_COALESCE_EN
        chk("coal_count", 32'(fifo_count), 32'd1);
`else
        chk("coal_count", 32'(fifo_count), 32'd2);
`endif
        cpu_busy = 1'b0;
        drain();
`ifdef EXCH_TX_COALESCE_EN
        chk("coal_pulses", 32'(pulses - base), 32'd1);
`else
        chk("coal_pulses", 32'(pulses - base), 32'd2);
`endif

        // Reset during a pulse with four entries still queued.
        cpu_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(5'(1 + i), 16'(7 * i), 5'(1 + i), 16'(7 * i));
        base = pulses;
        cpu_busy = 1'b0;
        wait_pulse(base + 1);
        chk("mid_rst_queued", 32'(fifo_count), 32'd4);
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_go", 32'(exchange_go), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_sent", 32'(sent_count), 32'd0);
        sb.delete();
        pulse_seen = 1'b0;
        prev_go = 1'b0;
        #2;
        HRESETn = 1'b1;
        base = pulses;
        repeat (20) tick();
        chk("post_rst_no_pulse", 32'(pulses - base), 32'd0);
        chk("post_rst_count", 32'(fifo_count), 32'd0);
        chk("post_rst_id", 32'(exchange_client_id), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
